// File: rtl/pcpi_issuer_pkg.sv
// Shared types and constants for the PCPI initiator and its watchdog.
package pcpi_issuer_pkg;

  localparam int XLEN = 32;
  localparam int PCPI_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    RELEASE
  } pcpi_issue_state_t;

endpackage

// File: rtl/pcpi_issuer_if.sv
// PCPI bundle between an initiator (Master) and a coprocessor (Slave).
interface PCP;
  import pcpi_issuer_pkg::*;

  logic            valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            wr;
  logic [XLEN-1:0] rd;
  logic            busy;
  logic            ready;

  modport Master (
    output valid, instruction, rs1, rs2,
    input  wr, rd, busy, ready
  );

  modport Slave (
    input  valid, instruction, rs1, rs2,
    output wr, rd, busy, ready
  );
endinterface

// File: rtl/pcpi_issuer_watchdog.sv
// Idle-cycle counter: expired is high once TIMEOUT_CYCLES-1 enabled cycles have
// accumulated since the last clr; the count holds there until cleared.
module pcpi_watchdog
  import pcpi_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pcpi_issuer.sv
// PCPI initiator: takes one request, runs the PCPI handshake toward a coprocessor
// and returns its result (or a timeout trap) on a valid/ready response port.
module pcpi_issuer
  import pcpi_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT_DEFAULT,
  parameter int LAT_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [XLEN-1:0]  rsp_rd,
  output logic             rsp_trap,
  output logic [LAT_W-1:0] rsp_cycles,
  PCP.Master               pcpi
);

  pcpi_issue_state_t state, state_next;
  logic load_req, take_ready, take_trap;
  logic wd_clr, wd_en, wd_expired;

  pcpi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Any busy cycle restarts the idle count, so only an unbroken idle run traps.
  assign wd_clr    = load_req || ((state == ISSUE) && pcpi.busy);
  assign wd_en     = (state == ISSUE) && !pcpi.busy;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // A ready seen in the same cycle the watchdog expires wins over the trap.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    take_ready = 1'b0;
    take_trap  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          load_req   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (pcpi.ready) begin
          take_ready = 1'b1;
          state_next = RESP;
        end else if (!pcpi.busy && wd_expired) begin
          take_trap  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = (pcpi.ready || pcpi.busy) ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!pcpi.ready && !pcpi.busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi.valid       <= 1'b0;
      pcpi.instruction <= '0;
      pcpi.rs1         <= '0;
      pcpi.rs2         <= '0;
      rsp_wr           <= 1'b0;
      rsp_rd           <= '0;
      rsp_trap         <= 1'b0;
      rsp_cycles       <= '0;
    end else begin
      if (load_req) begin
        pcpi.instruction <= req_insn;
        pcpi.rs1         <= req_rs1;
        pcpi.rs2         <= req_rs2;
        pcpi.valid       <= 1'b1;
        rsp_cycles       <= '0;
      end
      if ((state == ISSUE) && (rsp_cycles != '1)) begin
        rsp_cycles <= rsp_cycles + 1'b1;
      end
      if (take_ready) begin
        rsp_rd     <= pcpi.rd;
        rsp_wr     <= pcpi.wr;
        rsp_trap   <= 1'b0;
        pcpi.valid <= 1'b0;
      end else if (take_trap) begin
        rsp_rd     <= '0;
        rsp_wr     <= 1'b0;
        rsp_trap   <= 1'b1;
        pcpi.valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pcpi_issuer.md
# pcpi_issuer

PCPI initiator that drives the `PCP` interface from the master side toward a coprocessor such as the M-extension unit. It accepts one instruction and two operands on a valid/ready request port, then runs the full PCPI handshake. It returns the result, or a trap on timeout, on a valid/ready response port. It sits between the core's execute stage, or a bench sequencer, and any `PCP.Slave`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: number of consecutive non-busy, non-ready cycles in ISSUE that raises a trap.
- `LAT_W`, default 16: width of the saturating latency counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a request is offered.
- `req_ready`  out  1  the block accepts a request; equals (state==IDLE).
- `req_insn`  in  32  instruction word.
- `req_rs1`, `req_rs2`  in  XLEN  operands.
- `rsp_valid`  out  1  a response is held.
- `rsp_ready`  in  1  the consumer takes the response.
- `rsp_wr`  out  1  the coprocessor requested a register write.
- `rsp_rd`  out  XLEN  result.
- `rsp_trap`  out  1  timeout: no coprocessor claimed the instruction.
- `rsp_cycles`  out  LAT_W  cycles from `pcpi.valid` rise to `pcpi.ready` seen.
- `pcpi`  PCP.Master  bundle. Drives `valid`, `instruction`, `rs1`, `rs2`. Samples `wr`, `rd`, `busy`, `ready`.

## Operation
- States, in a package enum: IDLE, ISSUE, RESP, RELEASE.
- IDLE: when `req_valid` is high (`req_ready` is 1), latch insn/rs1/rs2 into `pcpi.instruction/rs1/rs2`, set `pcpi.valid`, clear the timer and `rsp_cycles`, and go to ISSUE.
- ISSUE:
  - `pcpi.valid` and the operands are held stable.
  - `rsp_cycles` increments each cycle and saturates at all-ones.
  - `pcpi.busy`=1 clears the timer.
  - Otherwise the timer increments.
- Leaving ISSUE, with `pcpi.ready` given priority over timeout in the same cycle:
  - `pcpi.ready`=1: capture `rd`/`wr`, set `rsp_trap`=0, clear `pcpi.valid`, go to RESP.
  - Timer reaches TIMEOUT_CYCLES-1 with no ready: `rsp_rd`=0, `rsp_wr`=0, `rsp_trap`=1, clear `pcpi.valid`, go to RESP.
- RESP:
  - `rsp_valid`=1; all rsp outputs are stable until `rsp_ready`.
  - On `rsp_ready`, go to RELEASE if `pcpi.ready` or `pcpi.busy` is high, else go to IDLE.
- RELEASE: `pcpi.valid` stays 0. Go to IDLE once `pcpi.ready`=0 and `pcpi.busy`=0. The slave may hold `ready` for several cycles after `valid` drops, and that stale ready must never be taken as a new completion. There is no timeout in RELEASE.
- `pcpi.rd` is sampled only on the first cycle `ready` is seen in ISSUE.
- Operand and instruction registers keep their last values after completion. Only `valid` qualifies them.

## Timing
- Reset values:
  - `pcpi.valid`, `pcpi.instruction`, `pcpi.rs1`, `pcpi.rs2`: 0.
  - `rsp_valid`, `rsp_wr`, `rsp_rd`, `rsp_trap`, `rsp_cycles`: 0.
  - `req_ready`: 1 (state is IDLE).
- Request accepted at edge N: `pcpi.valid` is high from N+1.
- `pcpi.ready` first seen high at edge M: `pcpi.valid` is low and `rsp_valid` is high from M+1. `rsp_cycles` is then M-N.
- Zero-wait response: `rsp_valid` and `rsp_ready` both high at edge K gives the next possible `req_ready` at K+1 (IDLE) or later (RELEASE).
- Timeout: with the slave idle, the trap appears TIMEOUT_CYCLES cycles after `valid` rises.
- Reset mid-operation: everything returns to reset values immediately. The pending request is dropped and no response is produced.
- `busy` pulses interleaved with idle cycles: each idle run counts from 0.

## Structure
- Shared package:
  - state enum `pcpi_issue_state_t`.
  - `PCPI_TIMEOUT_DEFAULT`=16.
  - existing `XLEN`.
- One sub-module, `pcpi_watchdog`: counter with `clr`, `en`, and an `expired` output, parameterised by TIMEOUT_CYCLES.
- The FSM, operand registers and response registers live in `pcpi_issuer`.

## Test plan
- MUL (funct7=0000001, funct3=000) with rs1=7, rs2=6, against the M-extension coprocessor -> `rsp_rd`=42, `rsp_wr`=1, `rsp_trap`=0, and `pcpi.valid` low one cycle after `ready`.
- DIVU with rs1=100, rs2=7 -> `rsp_rd`=14. `rsp_cycles` equals the divider latency. The second back-to-back request waits in RELEASE until `ready` falls, then yields 14 again (no false completion).
- Non-M instruction 0x00000013 with the slave idle -> `rsp_trap`=1, `rsp_rd`=0, `rsp_wr`=0, exactly 16 cycles after `valid` rise.
- Stub slave holding busy for 40 cycles, then ready with rd=0xDEADBEEF -> no trap, `rsp_rd`=0xDEADBEEF, `rsp_cycles`=41.
- `rsp_ready` held low for 5 cycles -> rsp outputs stable throughout, and `req_ready` stays 0.
- `resetn` pulled low in ISSUE -> all outputs 0 asynchronously, and after release a new MUL 3*5 returns 15.
